// File: rtl/read_bus_arbiter_if.sv
// rtl/read_bus_arbiter_if.sv - bundle of the fetch, load and slave read channels around the arbiter
interface read_bus_arbiter_if #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
);
    // fetch master (m0)
    logic [ADDR_BITS-1:0] m0_addr;
    logic                 m0_avalid;
    logic                 m0_aready;
    logic                 m0_flush;
    logic                 m0_valid;
    logic [DATA_BITS-1:0] m0_data;

    // load master (m1)
    logic [ADDR_BITS-1:0] m1_addr;
    logic                 m1_avalid;
    logic                 m1_aready;
    logic                 m1_valid;
    logic [DATA_BITS-1:0] m1_data;

    // shared in-order read slave
    logic [ADDR_BITS-1:0] s_addr;
    logic                 s_avalid;
    logic                 s_aready;
    logic                 s_valid;
    logic [DATA_BITS-1:0] s_data;

    // The arbiter serves the two masters and drives the shared slave.
    modport slave (
        input  m0_addr, m0_avalid, m0_flush,
        output m0_aready, m0_valid, m0_data,
        input  m1_addr, m1_avalid,
        output m1_aready, m1_valid, m1_data,
        output s_addr, s_avalid,
        input  s_aready, s_valid, s_data
    );

    // The environment: both requesters plus the read slave itself.
    modport master (
        output m0_addr, m0_avalid, m0_flush,
        input  m0_aready, m0_valid, m0_data,
        output m1_addr, m1_avalid,
        input  m1_aready, m1_valid, m1_data,
        input  s_addr, s_avalid,
        output s_aready, s_valid, s_data
    );
endinterface

// File: rtl/read_bus_arbiter.sv
// rtl/read_bus_arbiter.sv - round-robin two-master read arbiter with in-order response routing and fetch flush
module read_bus_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int ADDR_BITS   = 32,
    parameter int DATA_BITS   = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    read_bus_arbiter_if.slave              bus,
    output logic [$clog2(OUTSTANDING):0]   outstanding,
    output logic                           resp_error
);
    localparam int   PTR_BITS = $clog2(OUTSTANDING);
    localparam int   CNT_BITS = PTR_BITS + 1;
    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    // Route FIFO: owner of each accepted request plus a discard mark set by a fetch flush.
    logic                owner_q   [OUTSTANDING];
    logic                discard_q [OUTSTANDING];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [CNT_BITS-1:0] count;
    logic                last_grant;
    logic                resp_error_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic                head_owner;
    logic                head_discard;
    logic                pop;
    logic                push;
    logic                can_issue;
    logic                any_req;
    logic                grant_m1;
    logic [ADDR_BITS-1:0] gnt_addr;
    logic [DATA_BITS-1:0] resp_data;

    // Arbitration, issue gating and response steering; everything is forced to 0 while in reset.
    always_comb begin
        fifo_full    = (count == CNT_BITS'(OUTSTANDING));
        fifo_empty   = (count == '0);
        head_owner   = owner_q[rd_ptr];
        head_discard = discard_q[rd_ptr];
        pop          = !rst && bus.s_valid && !fifo_empty;
        // A full FIFO can still take a request when the head retires this same cycle.
        can_issue    = !fifo_full || pop;
        any_req      = bus.m0_avalid || bus.m1_avalid;
        // m1 wins only when alone or when m0 was served last.
        grant_m1     = bus.m1_avalid && (!bus.m0_avalid || (last_grant == OWNER_M0));
        gnt_addr     = grant_m1 ? bus.m1_addr : bus.m0_addr;
        resp_data    = bus.s_data;

        bus.s_avalid  = !rst && can_issue && any_req;
        bus.s_addr    = bus.s_avalid ? gnt_addr : '0;
        push          = bus.s_avalid && bus.s_aready;
        bus.m0_aready = push && !grant_m1;
        bus.m1_aready = push && grant_m1;

        // A flush in the same cycle as a fetch response kills that response too.
        bus.m0_valid  = pop && (head_owner == OWNER_M0) && !head_discard && !bus.m0_flush;
        bus.m1_valid  = pop && (head_owner == OWNER_M1);
        bus.m0_data   = bus.m0_valid ? resp_data : '0;
        bus.m1_data   = bus.m1_valid ? resp_data : '0;

        outstanding   = rst ? '0 : count;
        resp_error    = !rst && resp_error_q;
    end

    // Route FIFO bookkeeping, flush marking, round-robin history and sticky response error.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                owner_q[i]   <= OWNER_M0;
                discard_q[i] <= 1'b0;
            end
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            last_grant   <= OWNER_M1;
            resp_error_q <= 1'b0;
        end else begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (bus.m0_flush && (owner_q[i] == OWNER_M0)) begin
                    discard_q[i] <= 1'b1;
                end
            end
            // The request accepted alongside a flush is the redirect target, so it is written clean.
            if (push) begin
                owner_q[wr_ptr]   <= grant_m1;
                discard_q[wr_ptr] <= 1'b0;
                wr_ptr            <= wr_ptr + 1'b1;
                last_grant        <= grant_m1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.s_valid && fifo_empty) begin
                resp_error_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_read_bus_arbiter.sv
// tb/tb_read_bus_arbiter.sv - directed self-checking bench for read_bus_arbiter
module tb_read_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] outstanding;
    logic       resp_error;
    int         checks   = 0;
    int         failures = 0;

    read_bus_arbiter_if #(.ADDR_BITS(32), .DATA_BITS(32)) bus ();

    read_bus_arbiter #(.OUTSTANDING(4), .ADDR_BITS(32), .DATA_BITS(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .outstanding (outstanding),
        .resp_error  (resp_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.m0_addr   = '0;
        bus.m0_avalid = 1'b0;
        bus.m0_flush  = 1'b0;
        bus.m1_addr   = '0;
        bus.m1_avalid = 1'b0;
        bus.s_aready  = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        bus.m0_avalid = 1'b1;
        bus.m1_avalid = 1'b1;
        bus.m0_addr   = 32'h0000_0040;
        bus.s_aready  = 1'b1;
        bus.s_valid   = 1'b1;
        bus.s_data    = 32'h1234_5678;
        #1;
        checks++;
        if ({bus.s_avalid, bus.m0_aready, bus.m1_aready, bus.m0_valid, bus.m1_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got %b want 00000",
                     {bus.s_avalid, bus.m0_aready, bus.m1_aready, bus.m0_valid, bus.m1_valid});
        end
        checks++;
        if (bus.s_addr !== 32'h0 || bus.m0_data !== 32'h0 || bus.m1_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_buses got s_addr=%h m0_data=%h m1_data=%h want all 0",
                     bus.s_addr, bus.m0_data, bus.m1_data);
        end
        tick();
        idle();
        rst = 1'b0;
        #1;
        checks++;
        if (outstanding !== 3'd0 || resp_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got outstanding=%0d resp_error=%b want 0 0", outstanding, resp_error);
        end
        tick();
    endtask

    task automatic test_m0_only();
        logic [3:0]  exp_flags;
        logic [31:0] exp_data;
        logic [31:0] exp_addr;
        int          exp_out;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle();
            bus.s_aready = 1'b1;
            exp_addr = 32'h0;
            exp_data = 32'h0;
            if (i < 3) begin
                bus.m0_avalid = 1'b1;
                bus.m0_addr   = 32'(32'h100 + 4 * i);
                exp_addr      = 32'(32'h100 + 4 * i);
            end
            if (i >= 2 && i < 5) begin
                bus.s_valid = 1'b1;
                bus.s_data  = 32'(32'hD000_0100 + 4 * (i - 2));
                exp_data    = 32'(32'hD000_0100 + 4 * (i - 2));
            end
            exp_flags = {i < 3, 1'b0, (i >= 2 && i < 5), 1'b0};
            exp_out   = ((i < 3) ? i : 3) - ((i > 2) ? i - 2 : 0);
            #1;
            checks++;
            if ({bus.m0_aready, bus.m1_aready, bus.m0_valid, bus.m1_valid} !== exp_flags) begin
                failures++;
                $display("FAIL m0_only_flags cycle %0d got %b want %b", i,
                         {bus.m0_aready, bus.m1_aready, bus.m0_valid, bus.m1_valid}, exp_flags);
            end
            checks++;
            if (bus.m0_data !== exp_data || bus.s_addr !== exp_addr) begin
                failures++;
                $display("FAIL m0_only_data cycle %0d got m0_data=%h s_addr=%h want %h %h", i,
                         bus.m0_data, bus.s_addr, exp_data, exp_addr);
            end
            checks++;
            if (outstanding !== 3'(exp_out)) begin
                failures++;
                $display("FAIL m0_only_outstanding cycle %0d got %0d want %0d", i, outstanding, exp_out);
            end
            tick();
        end
    endtask

    task automatic test_alternate();
        logic [3:0]  exp_flags;
        logic [31:0] exp_addr;
        logic [31:0] exp_m0;
        logic [31:0] exp_m1;
        logic        gm0, gm1, rm0, rm1;
        int          exp_out;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            bus.s_aready = 1'b1;
            if (i < 4) begin
                bus.m0_avalid = 1'b1;
                bus.m1_avalid = 1'b1;
                bus.m0_addr   = 32'(32'h1000 + 4 * ((i + 1) / 2));
                bus.m1_addr   = 32'(32'h2000 + 4 * (i / 2));
            end
            if (i >= 1) begin
                bus.s_valid = 1'b1;
                bus.s_data  = 32'(32'hE000_0000 + i - 1);
            end
            gm0 = (i < 4) && (i % 2 == 0);
            gm1 = (i < 4) && (i % 2 == 1);
            rm0 = (i >= 1) && ((i - 1) % 2 == 0);
            rm1 = (i >= 1) && ((i - 1) % 2 == 1);
            exp_flags = {gm0, gm1, rm0, rm1};
            exp_addr  = gm0 ? 32'(32'h1000 + 4 * ((i + 1) / 2)) : gm1 ? 32'(32'h2000 + 4 * (i / 2)) : 32'h0;
            exp_m0    = rm0 ? 32'(32'hE000_0000 + i - 1) : 32'h0;
            exp_m1    = rm1 ? 32'(32'hE000_0000 + i - 1) : 32'h0;
            exp_out   = ((i < 4) ? i : 4) - ((i > 1) ? i - 1 : 0);
            #1;
            checks++;
            if ({bus.m0_aready, bus.m1_aready, bus.m0_valid, bus.m1_valid} !== exp_flags) begin
                failures++;
                $display("FAIL alternate_flags cycle %0d got %b want %b", i,
                         {bus.m0_aready, bus.m1_aready, bus.m0_valid, bus.m1_valid}, exp_flags);
            end
            checks++;
            if (bus.s_addr !== exp_addr || bus.m0_data !== exp_m0 || bus.m1_data !== exp_m1) begin
                failures++;
                $display("FAIL alternate_data cycle %0d got s_addr=%h m0=%h m1=%h want %h %h %h", i,
                         bus.s_addr, bus.m0_data, bus.m1_data, exp_addr, exp_m0, exp_m1);
            end
            checks++;
            if (outstanding !== 3'(exp_out)) begin
                failures++;
                $display("FAIL alternate_outstanding cycle %0d got %0d want %0d", i, outstanding, exp_out);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (outstanding !== 3'd0) begin
            failures++;
            $display("FAIL alternate_drained got %0d want 0", outstanding);
        end
    endtask

    task automatic test_full();
        logic        exp_acc;
        logic        exp_v;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle();
            bus.s_aready  = 1'b1;
            bus.m0_avalid = 1'b1;
            bus.m0_addr   = 32'(32'h300 + 4 * ((i < 4) ? i : 4));
            if (i == 5) begin
                bus.s_valid = 1'b1;
                bus.s_data  = 32'hC000_0300;
            end
            exp_acc = (i != 4);
            exp_v   = (i == 5);
            #1;
            checks++;
            if ({bus.s_avalid, bus.m0_aready, bus.m0_valid} !== {exp_acc, exp_acc, exp_v}) begin
                failures++;
                $display("FAIL full_flags cycle %0d got %b want %b", i,
                         {bus.s_avalid, bus.m0_aready, bus.m0_valid}, {exp_acc, exp_acc, exp_v});
            end
            checks++;
            if (outstanding !== 3'((i < 4) ? i : 4)) begin
                failures++;
                $display("FAIL full_outstanding cycle %0d got %0d want %0d", i, outstanding, (i < 4) ? i : 4);
            end
            if (i == 5) begin
                checks++;
                if (bus.m0_data !== 32'hC000_0300) begin
                    failures++;
                    $display("FAIL full_pop_data got %h want c0000300", bus.m0_data);
                end
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            bus.s_valid = 1'b1;
            bus.s_data  = 32'(32'hC000_0304 + 4 * i);
            #1;
            checks++;
            if (bus.m0_valid !== 1'b1 || bus.m0_data !== 32'(32'hC000_0304 + 4 * i) || outstanding !== 3'(4 - i)) begin
                failures++;
                $display("FAIL full_drain %0d got valid=%b data=%h out=%0d want 1 %h %0d", i,
                         bus.m0_valid, bus.m0_data, outstanding, 32'(32'hC000_0304 + 4 * i), 4 - i);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (outstanding !== 3'd0) begin
            failures++;
            $display("FAIL full_drained got %0d want 0", outstanding);
        end
    endtask

    task automatic test_flush();
        logic [3:0]  exp_flags;
        logic [31:0] exp_m0;
        logic [31:0] exp_m1;
        int          exp_out;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            idle();
            bus.s_aready = 1'b1;
            exp_flags = 4'b0000;
            exp_m0    = 32'h0;
            exp_m1    = 32'h0;
            case (i)
                0: begin bus.m0_avalid = 1'b1; bus.m0_addr = 32'h500; exp_flags = 4'b1000; exp_out = 0; end
                1: begin bus.m1_avalid = 1'b1; bus.m1_addr = 32'h600; exp_flags = 4'b0100; exp_out = 1; end
                2: begin bus.m0_avalid = 1'b1; bus.m0_addr = 32'h504; exp_flags = 4'b1000; exp_out = 2; end
                3: begin
                    bus.m0_flush  = 1'b1;
                    bus.m0_avalid = 1'b1;
                    bus.m0_addr   = 32'h200;
                    bus.s_valid   = 1'b1;
                    bus.s_data    = 32'h0000_BAD0;
                    exp_flags     = 4'b1000;
                    exp_out       = 3;
                end
                4: begin bus.s_valid = 1'b1; bus.s_data = 32'h0000_6000; exp_flags = 4'b0001; exp_m1 = 32'h6000; exp_out = 3; end
                5: begin bus.s_valid = 1'b1; bus.s_data = 32'h0000_BAD1; exp_out = 2; end
                6: begin bus.s_valid = 1'b1; bus.s_data = 32'h0000_2000; exp_flags = 4'b0010; exp_m0 = 32'h2000; exp_out = 1; end
                default: exp_out = 0;
            endcase
            #1;
            checks++;
            if ({bus.m0_aready, bus.m1_aready, bus.m0_valid, bus.m1_valid} !== exp_flags) begin
                failures++;
                $display("FAIL flush_flags step %0d got %b want %b", i,
                         {bus.m0_aready, bus.m1_aready, bus.m0_valid, bus.m1_valid}, exp_flags);
            end
            checks++;
            if (bus.m0_data !== exp_m0 || bus.m1_data !== exp_m1 || outstanding !== 3'(exp_out)) begin
                failures++;
                $display("FAIL flush_data step %0d got m0=%h m1=%h out=%0d want %h %h %0d", i,
                         bus.m0_data, bus.m1_data, outstanding, exp_m0, exp_m1, exp_out);
            end
            tick();
        end
    endtask

    task automatic test_resp_error();
        do_reset();
        idle();
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h0000_0055;
        #1;
        checks++;
        if ({bus.m0_valid, bus.m1_valid, resp_error} !== 3'b000) begin
            failures++;
            $display("FAIL stray_resp_same_cycle got %b want 000", {bus.m0_valid, bus.m1_valid, resp_error});
        end
        tick();
        idle();
        #1;
        checks++;
        if (resp_error !== 1'b1 || outstanding !== 3'd0) begin
            failures++;
            $display("FAIL stray_resp_set got err=%b out=%0d want 1 0", resp_error, outstanding);
        end
        tick();
        checks++;
        if (resp_error !== 1'b1) begin
            failures++;
            $display("FAIL stray_resp_sticky got %b want 1", resp_error);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (resp_error !== 1'b0 || outstanding !== 3'd0) begin
            failures++;
            $display("FAIL resp_error_cleared got err=%b out=%0d want 0 0", resp_error, outstanding);
        end
        bus.m0_avalid = 1'b1;
        bus.m0_addr   = 32'h0000_0800;
        bus.s_aready  = 1'b1;
        tick();
        idle();
        #1;
        checks++;
        if (outstanding !== 3'd1) begin
            failures++;
            $display("FAIL midop_accept got out=%0d want 1", outstanding);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h0000_0800;
        #1;
        checks++;
        if ({bus.m0_valid, outstanding} !== 4'b0000) begin
            failures++;
            $display("FAIL midop_lost got valid=%b out=%0d want 0 0", bus.m0_valid, outstanding);
        end
        tick();
        idle();
        #1;
        checks++;
        if (resp_error !== 1'b1) begin
            failures++;
            $display("FAIL midop_resp_error got %b want 1", resp_error);
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic [3:0]  exp_flags;
        logic [31:0] exp_m0;
        logic [31:0] exp_m1;
        logic        req, resp, req_m1, resp_m1;
        int          k;
        int          exp_out;
        do_reset();
        for (int i = 0; i < 19; i++) begin
            idle();
            bus.s_aready = 1'b1;
            req    = (i < 16);
            req_m1 = (i % 2 == 1);
            resp   = (i >= 3);
            k      = i - 3;
            resp_m1 = (k % 2 == 1);
            if (req && !req_m1) begin bus.m0_avalid = 1'b1; bus.m0_addr = 32'(32'h700 + 4 * i); end
            if (req && req_m1)  begin bus.m1_avalid = 1'b1; bus.m1_addr = 32'(32'h700 + 4 * i); end
            if (resp) begin bus.s_valid = 1'b1; bus.s_data = 32'(32'hF000 + k); end
            exp_flags = {req && !req_m1, req && req_m1, resp && !resp_m1, resp && resp_m1};
            exp_m0    = (resp && !resp_m1) ? 32'(32'hF000 + k) : 32'h0;
            exp_m1    = (resp && resp_m1) ? 32'(32'hF000 + k) : 32'h0;
            exp_out   = ((i < 16) ? i : 16) - ((i > 3) ? i - 3 : 0);
            #1;
            checks++;
            if ({bus.m0_aready, bus.m1_aready, bus.m0_valid, bus.m1_valid} !== exp_flags) begin
                failures++;
                $display("FAIL wrap_flags cycle %0d got %b want %b", i,
                         {bus.m0_aready, bus.m1_aready, bus.m0_valid, bus.m1_valid}, exp_flags);
            end
            checks++;
            if (bus.m0_data !== exp_m0 || bus.m1_data !== exp_m1 || outstanding !== 3'(exp_out)) begin
                failures++;
                $display("FAIL wrap_data cycle %0d got m0=%h m1=%h out=%0d want %h %h %0d", i,
                         bus.m0_data, bus.m1_data, outstanding, exp_m0, exp_m1, exp_out);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (outstanding !== 3'd0 || resp_error !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end got out=%0d err=%b want 0 0", outstanding, resp_error);
        end
    endtask

    initial begin
        test_reset();
        test_m0_only();
        test_alternate();
        test_full();
        test_flush();
        test_resp_error();
        test_back_to_back_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
